// File: rtl/il_pkg.sv
// Shared types for the interleaver-core scheduler: FSM states and the in-flight tag.
package il_pkg;

    localparam int BLK_W_DEF = 28;
    localparam int MAX_NCH   = 8;
    localparam int TAG_CH_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic                vld;
        logic [TAG_CH_W-1:0] ch;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a pointer that
// moves past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int NCH   = 2,
    parameter int IDX_W = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    input  logic             advance,
    output logic [NCH-1:0]   grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   sum;
    logic             found;

    // Candidate index wraps modulo NCH; the extra bit keeps the sum from overflowing
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        for (int k = 0; k < NCH; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NCH)) begin
                sum = sum - (IDX_W+1)'(NCH);
            end
            if (!found && req[sum[IDX_W-1:0]]) begin
                found                    = 1'b1;
                grant[sum[IDX_W-1:0]]    = 1'b1;
                grant_idx                = sum[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == IDX_W'(NCH-1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/il_core_scheduler.sv
// Shares one fixed-latency interleaver core between NCH requesters: round-robin
// issue, tag pipe matching core latency, and return routing to the owner.
module il_core_scheduler
    import il_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int BLK_W    = BLK_W_DEF,
    parameter int CORE_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    flush,
    input  logic [NCH-1:0]          ch_valid,
    input  logic [NCH*BLK_W-1:0]    ch_data,
    output logic [NCH-1:0]          ch_ready,
    output logic                    core_en,
    output logic [BLK_W-1:0]        core_data,
    input  logic                    core_en_out,
    input  logic [BLK_W-1:0]        core_data_out,
    output logic                    out_valid,
    output logic [$clog2(NCH)-1:0]  out_ch,
    output logic [BLK_W-1:0]        out_data,
    output logic                    idle,
    output logic                    err,
    output logic [NCH*CNT_W-1:0]    issued_cnt
);

    localparam int IDX_W = $clog2(NCH);

    state_t           state;
    state_t           state_nx;
    logic             grant_en;
    logic [NCH-1:0]   grant;
    logic [IDX_W-1:0] grant_idx;
    logic             transfer;
    logic [BLK_W-1:0] sel_data;
    logic [IDX_W-1:0] issue_ch;
    tag_t             pipe [CORE_LAT];
    tag_t             head;
    logic             pipe_busy;
    logic             unused_head_ch;

    // A flush in RUN blocks the grant in its own cycle
    assign grant_en = (state == RUN) && !flush;
    assign ch_ready = grant;
    assign transfer = |grant;
    assign head     = pipe[CORE_LAT-1];
    assign unused_head_ch = ^head.ch;

    rr_arbiter #(
        .NCH   (NCH),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (ch_valid & {NCH{grant_en}}),
        .advance   (transfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_data  = '0;
        pipe_busy = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                sel_data = ch_data[i*BLK_W +: BLK_W];
            end
        end
        for (int i = 0; i < CORE_LAT; i++) begin
            pipe_busy = pipe_busy | pipe[i].vld;
        end
    end

    // DRAIN waits until neither the issue register nor the tag pipe holds a block
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (flush) state_nx = DRAIN;
            DRAIN:   if (!core_en && !pipe_busy) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idle  <= 1'b1;
        end else begin
            state <= state_nx;
            idle  <= (state_nx == IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_en    <= 1'b0;
            core_data  <= '0;
            issue_ch   <= '0;
            issued_cnt <= '0;
        end else begin
            core_en <= transfer;
            if (transfer) begin
                core_data <= sel_data;
                issue_ch  <= grant_idx;
            end
            for (int i = 0; i < NCH; i++) begin
                if (grant[i]) begin
                    issued_cnt[i*CNT_W +: CNT_W] <= issued_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    // The tag enters alongside core_en so the head lines up with core_en_out
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CORE_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= {core_en, TAG_CH_W'(issue_ch)};
            for (int i = 1; i < CORE_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            out_valid <= core_en_out & head.vld;
            if (core_en_out && head.vld) begin
                out_ch   <= head.ch[IDX_W-1:0];
                out_data <= core_data_out;
            end
            if (core_en_out != head.vld) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_il_core_scheduler.sv
// Randomized directed bench for il_core_scheduler: NCH=2/CORE_LAT=1 against a
// scoreboard model, plus an NCH=3/CORE_LAT=4 counter-wrap run.
module tb_il_core_scheduler;

    localparam int W  = 28;
    localparam int CW = 16;
    localparam int N1 = 2;
    localparam int L1 = 1;
    localparam int N2 = 3;
    localparam int L2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1 (NCH=2, CORE_LAT=1)
    logic            rst, start, flush, inject;
    logic [N1-1:0]   ch_valid, ch_ready;
    logic [N1*W-1:0] ch_data;
    logic            core_en, core_en_out, out_valid, idle, err;
    logic [W-1:0]    core_data, core_data_out, out_data;
    logic [0:0]      out_ch;
    logic [N1*CW-1:0] issued_cnt;

    // DUT 2 (NCH=3, CORE_LAT=4)
    logic            rst2, start2, flush2;
    logic [N2-1:0]   ch_valid2, ch_ready2;
    logic [N2*W-1:0] ch_data2;
    logic            core_en2, core_en_out2, out_valid2, idle2, err2;
    logic [W-1:0]    core_data2, core_data_out2, out_data2;
    logic [1:0]      out_ch2;
    logic [N2*CW-1:0] issued_cnt2;

    int total = 0;
    int bad   = 0;

    function automatic logic [W-1:0] core_fn(input logic [W-1:0] x);
        return {x[W-6:0], x[W-1:W-5]} ^ 28'h0A5C3F1;
    endfunction

    il_core_scheduler #(.NCH(N1), .BLK_W(W), .CORE_LAT(L1), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
        .core_en(core_en), .core_data(core_data),
        .core_en_out(core_en_out), .core_data_out(core_data_out),
        .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data),
        .idle(idle), .err(err), .issued_cnt(issued_cnt)
    );

    il_core_scheduler #(.NCH(N2), .BLK_W(W), .CORE_LAT(L2), .CNT_W(CW)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .flush(flush2),
        .ch_valid(ch_valid2), .ch_data(ch_data2), .ch_ready(ch_ready2),
        .core_en(core_en2), .core_data(core_data2),
        .core_en_out(core_en_out2), .core_data_out(core_data_out2),
        .out_valid(out_valid2), .out_ch(out_ch2), .out_data(out_data2),
        .idle(idle2), .err(err2), .issued_cnt(issued_cnt2)
    );

    // Behavioural cores: pure delay lines with a fixed bit permutation
    logic         c1_e [L1];
    logic [W-1:0] c1_d [L1];
    logic         c2_e [L2];
    logic [W-1:0] c2_d [L2];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < L1; i++) begin c1_e[i] <= 1'b0; c1_d[i] <= '0; end
        end else begin
            c1_e[0] <= core_en;
            c1_d[0] <= core_data;
            for (int i = 1; i < L1; i++) begin c1_e[i] <= c1_e[i-1]; c1_d[i] <= c1_d[i-1]; end
        end
    end

    always @(posedge clk) begin
        if (rst2) begin
            for (int i = 0; i < L2; i++) begin c2_e[i] <= 1'b0; c2_d[i] <= '0; end
        end else begin
            c2_e[0] <= core_en2;
            c2_d[0] <= core_data2;
            for (int i = 1; i < L2; i++) begin c2_e[i] <= c2_e[i-1]; c2_d[i] <= c2_d[i-1]; end
        end
    end

    assign core_en_out    = c1_e[L1-1] | inject;
    assign core_data_out  = core_fn(c1_d[L1-1]);
    assign core_en_out2   = c2_e[L2-1];
    assign core_data_out2 = core_fn(c2_d[L2-1]);

    // Reference model: mode, RR pointer, counters and a scoreboard of due results
    typedef struct {
        int           due;
        int           ch;
        logic [W-1:0] data;
    } exp_t;

    exp_t          sb [$];
    int            m_state = 0;
    int            m_ptr   = 0;
    logic [CW-1:0] m_cnt [N1] = '{default: '0};
    logic          m_err   = 1'b0;
    logic          m_cen   = 1'b0;
    logic [W-1:0]  m_cdata = '0;
    int            cyc     = 0;

    task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic f,
                                 input logic [N1-1:0] v, input logic [W-1:0] d0,
                                 input logic [W-1:0] d1, input logic inj);
        rst      = r;
        start    = s;
        flush    = f;
        ch_valid = v;
        ch_data  = {d1, d0};
        inject   = inj;
    endtask

    task automatic checkOutput();
        int           g;
        int           idx;
        int           hit;
        bit           pending;
        bit           busy;
        logic [N1-1:0] exp_ready;
        logic [W-1:0] dsel;
        @(negedge clk);
        g = -1;
        if (m_state == 1 && !flush) begin
            for (int k = 0; k < N1; k++) begin
                idx = (m_ptr + k) % N1;
                if (g < 0 && ch_valid[idx]) g = idx;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        compare("ch_ready", 64'(ch_ready), 64'(exp_ready));
        compare("core_en", 64'(core_en), 64'(m_cen));
        if (m_cen) compare("core_data", 64'(core_data), 64'(m_cdata));
        hit = -1;
        foreach (sb[i]) if (sb[i].due == cyc) hit = i;
        compare("out_valid", 64'(out_valid), 64'(hit >= 0));
        if (hit >= 0) begin
            compare("out_ch", 64'(out_ch), 64'(sb[hit].ch));
            compare("out_data", 64'(out_data), 64'(sb[hit].data));
        end
        compare("idle", 64'(idle), 64'(m_state == 0));
        compare("err", 64'(err), 64'(m_err));
        compare("cnt0", 64'(issued_cnt[0 +: CW]), 64'(m_cnt[0]));
        compare("cnt1", 64'(issued_cnt[CW +: CW]), 64'(m_cnt[1]));

        if (rst) begin
            m_state = 0; m_ptr = 0; m_err = 1'b0; m_cen = 1'b0;
            m_cnt[0] = '0; m_cnt[1] = '0;
            sb.delete();
        end else begin
            if (inject) begin
                pending = 0;
                foreach (sb[i]) if (sb[i].due == cyc + 1) pending = 1;
                if (!pending) m_err = 1'b1;
            end
            busy = 0;
            foreach (sb[i]) if (sb[i].due > cyc) busy = 1;
            case (m_state)
                0: if (start) m_state = 1;
                1: if (flush) m_state = 2;
                2: if (!busy) m_state = 0;
                default: m_state = 0;
            endcase
            if (g >= 0) begin
                dsel = ch_data[g*W +: W];
                sb.push_back('{due: cyc + L1 + 2, ch: g, data: core_fn(dsel)});
                m_cen    = 1'b1;
                m_cdata  = dsel;
                m_cnt[g] = m_cnt[g] + 16'd1;
                m_ptr    = (g + 1) % N1;
            end else begin
                m_cen = 1'b0;
            end
            while (sb.size() > 0 && sb[0].due <= cyc) void'(sb.pop_front());
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        typedef struct { int due; logic [W-1:0] data; } exp2_t;
        exp2_t        q2 [$];
        int           cyc2;
        int           rcv;
        logic         exp_v;
        logic [W-1:0] d;

        applyStimulus(1, 0, 0, 2'b00, '0, '0, 0);
        rst2 = 1'b1; start2 = 1'b0; flush2 = 1'b0; ch_valid2 = '0; ch_data2 = '0;
        checkOutput();
        checkOutput();

        // Single block from channel 0
        applyStimulus(0, 1, 0, 2'b00, '0, '0, 0); checkOutput();
        applyStimulus(0, 0, 0, 2'b01, 28'h3E1EDE5, '0, 0); checkOutput();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 2'b00, '0, '0, 0); checkOutput();
        end
        compare("t1_cnt0", 64'(issued_cnt[0 +: CW]), 64'd1);

        // Both channels for six cycles from a fresh pointer
        applyStimulus(1, 0, 0, 2'b00, '0, '0, 0); checkOutput();
        applyStimulus(0, 1, 0, 2'b00, '0, '0, 0); checkOutput();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 0, 2'b11, W'($urandom()), W'($urandom()), 0); checkOutput();
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 2'b00, '0, '0, 0); checkOutput();
        end
        compare("t2_cnt", 64'(issued_cnt), 64'({16'd3, 16'd3}));

        // Flush under load, drain, restart from the saved pointer
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 2'b11, W'($urandom()), W'($urandom()), 0); checkOutput();
        end
        applyStimulus(0, 0, 1, 2'b11, W'($urandom()), W'($urandom()), 0); checkOutput();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 2'b11, W'($urandom()), W'($urandom()), 0); checkOutput();
        end
        compare("t3_idle", 64'(idle), 64'd1);
        applyStimulus(0, 1, 1, 2'b00, '0, '0, 0); checkOutput();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 2'b11, W'($urandom()), W'($urandom()), 0); checkOutput();
        end
        applyStimulus(0, 0, 1, 2'b00, '0, '0, 0); checkOutput();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 2'b00, '0, '0, 0); checkOutput();
        end

        // Spurious result strobe with nothing in flight
        applyStimulus(0, 0, 0, 2'b00, '0, '0, 1); checkOutput();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 2'b00, '0, '0, 0); checkOutput();
        end
        compare("t4_err_sticky", 64'(err), 64'd1);

        // Reset with one block in flight
        applyStimulus(1, 0, 0, 2'b00, '0, '0, 0); checkOutput();
        applyStimulus(0, 1, 0, 2'b00, '0, '0, 0); checkOutput();
        applyStimulus(0, 0, 0, 2'b10, '0, W'($urandom()), 0); checkOutput();
        applyStimulus(1, 0, 0, 2'b00, '0, '0, 0); checkOutput();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 2'b00, '0, '0, 0); checkOutput();
        end
        compare("t5_cnt", 64'(issued_cnt), 64'd0);
        compare("t5_idle", 64'(idle), 64'd1);

        // Random traffic with occasional start, flush and reset
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0,
                          $urandom_range(0, 19) == 0, N1'($urandom()),
                          W'($urandom()), W'($urandom()), 0);
            checkOutput();
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 0, 2'b00, '0, '0, 0); checkOutput();
        end

        // NCH=3, CORE_LAT=4: channel 1 alone until its counter wraps
        rst2 = 1'b0; start2 = 1'b1;
        @(negedge clk);
        compare("t6_ready_idle", 64'(ch_ready2), 64'd0);
        @(posedge clk); #1;
        start2 = 1'b0;
        cyc2 = 0;
        rcv  = 0;
        for (int i = 0; i < 70006; i++) begin
            d = W'($urandom());
            ch_valid2 = (i < 70000) ? 3'b010 : 3'b000;
            ch_data2  = {W'(0), d, W'(0)};
            @(negedge clk);
            compare("t6_ready", 64'(ch_ready2), (i < 70000) ? 64'd2 : 64'd0);
            if (i < 70000) q2.push_back('{due: cyc2 + L2 + 2, data: core_fn(d)});
            exp_v = (q2.size() > 0) && (q2[0].due == cyc2);
            compare("t6_out_valid", 64'(out_valid2), 64'(exp_v));
            if (out_valid2) rcv++;
            if (exp_v) begin
                compare("t6_out_ch", 64'(out_ch2), 64'd1);
                compare("t6_out_data", 64'(out_data2), 64'(q2[0].data));
                void'(q2.pop_front());
            end
            cyc2++;
            @(posedge clk); #1;
        end
        compare("t6_cnt1_wrap", 64'(issued_cnt2[CW +: CW]), 64'd4464);
        compare("t6_cnt0", 64'(issued_cnt2[0 +: CW]), 64'd0);
        compare("t6_cnt2", 64'(issued_cnt2[2*CW +: CW]), 64'd0);
        compare("t6_err", 64'(err2), 64'd0);
        compare("t6_received", 64'(rcv), 64'd70000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
